nibble_serial_addsub: RTL and testbench

Multi-nibble serial adder/subtracter. It accepts a wide operand pair and computes A+B or A−B one 4-bit slice per clock, least-significant nibble first, carrying between slices through a registered carry. It reuses the nibble add/sub datapath style, in which B is XORed with the op bit and the op bit is the initial carry-in. It sits directly upstream of the result consumers and extends the 4-bit add/sub stage to word width without a wide carry chain.

---
 rtl/nibble_serial_addsub_if.sv | 30 +++
 rtl/nibble_serial_addsub.sv | 102 ++++++++++
 tb/tb_nibble_serial_addsub.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_if.sv
// Operand/result bundle for the nibble-serial add/subtract unit.
// The master drives a request (start/op/a/b), the slave returns status and the registered result.
interface nibble_serial_addsub_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    // Handshake: a request is taken on any rising edge where start=1 and busy=0
    // (this includes the done cycle). The operands are sampled only on that edge.
    // done is a one-cycle pulse marking that result/carry_out/overflow were just updated.
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry_out, overflow
    );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Word-width add/subtract built from one 4-bit slice per clock, LSB nibble first,
// with a registered carry between slices instead of a wide carry chain.
module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    nibble_serial_addsub_if.slave                 bus,
    output logic [$clog2(NIBBLES)+1:0]            dbg
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e         state_q;
    state_e         state_d;
    logic [W-1:0]   a_q;
    logic [W-1:0]   beff_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   acc_d;
    logic           op_q;
    logic           carry_q;
    logic [IW-1:0]  idx_q;
    logic [3:0]     a_nib;
    logic [3:0]     b_nib;
    logic [4:0]     sum;
    logic           last;
    logic           accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN:  if (last)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / slice decode
    always_comb begin
        accept   = (state_q == IDLE) && bus.start;
        last     = (state_q == RUN) && (idx_q == IW'(NIBBLES - 1));
        a_nib    = a_q[{idx_q, 2'b00} +: 4];
        b_nib    = beff_q[{idx_q, 2'b00} +: 4];
        sum      = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        acc_d    = acc_q;
        acc_d[{idx_q, 2'b00} +: 4] = sum[3:0];
        bus.busy = (state_q == RUN);
        dbg      = {state_q == RUN, op_q, idx_q};
    end

    // Datapath; the published result only moves on the edge that raises done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q           <= '0;
            beff_q        <= '0;
            acc_q         <= '0;
            op_q          <= 1'b0;
            carry_q       <= 1'b0;
            idx_q         <= '0;
            bus.done      <= 1'b0;
            bus.result    <= '0;
            bus.carry_out <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (accept) begin
                a_q     <= bus.a;
                beff_q  <= bus.b ^ {W{bus.op}};
                op_q    <= bus.op;
                carry_q <= bus.op;
                idx_q   <= '0;
            end else if (state_q == RUN) begin
                acc_q   <= acc_d;
                carry_q <= sum[4];
                if (last) begin
                    idx_q         <= '0;
                    bus.done      <= 1'b1;
                    bus.result    <= acc_d;
                    bus.carry_out <= sum[4];
                    bus.overflow  <= (a_q[W-1] == beff_q[W-1]) && (sum[3] != a_q[W-1]);
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub with NIBBLES=4: arithmetic vectors,
// latency/busy timing, start handling while busy, back-to-back, result hold and reset abort.
module tb_nibble_serial_addsub;
    logic       clk;
    logic       rst_n;
    logic [3:0] dbg;
    int         checks;
    int         errors;

    nibble_serial_addsub_if #(.NIBBLES(4)) bus ();

    nibble_serial_addsub #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .dbg   (dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present a request before the edge, drop start just after it
    task automatic start_op(input logic o, input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done; lat = -1 on timeout
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", bus.result); end
        checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", bus.carry_out); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_timing;
        int lat, bc;
        start_op(1'b0, 16'h1234, 16'h0FFF);
        wait_done(lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL add_latency got %0d want 5", lat); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL add_busy_cycles got %0d want 4", bc); end
        checks++; if (bus.result !== 16'h2233) begin errors++; $display("FAIL add_result got %h want 2233", bus.result); end
        checks++; if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL add_carry got %b want 0", bus.carry_out); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL add_ovf got %b want 0", bus.overflow); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b want 0", bus.done); end
    endtask

    // Subtract and boundary vectors: {op, a, b, result, carry_out, overflow}
    task automatic test_vectors;
        logic        v_op [5];
        logic [15:0] v_a  [5];
        logic [15:0] v_b  [5];
        logic [15:0] v_r  [5];
        logic        v_c  [5];
        logic        v_v  [5];
        int lat, bc;
        v_op[0] = 1; v_a[0] = 16'h0005; v_b[0] = 16'h0003; v_r[0] = 16'h0002; v_c[0] = 1; v_v[0] = 0;
        v_op[1] = 1; v_a[1] = 16'h0003; v_b[1] = 16'h0005; v_r[1] = 16'hFFFE; v_c[1] = 0; v_v[1] = 0;
        v_op[2] = 0; v_a[2] = 16'h7FFF; v_b[2] = 16'h0001; v_r[2] = 16'h8000; v_c[2] = 0; v_v[2] = 1;
        v_op[3] = 0; v_a[3] = 16'hFFFF; v_b[3] = 16'h0001; v_r[3] = 16'h0000; v_c[3] = 1; v_v[3] = 0;
        v_op[4] = 1; v_a[4] = 16'h8000; v_b[4] = 16'h0001; v_r[4] = 16'h7FFF; v_c[4] = 1; v_v[4] = 1;
        for (int i = 0; i < 5; i++) begin
            start_op(v_op[i], v_a[i], v_b[i]);
            wait_done(lat, bc);
            checks++; if (lat !== 5) begin errors++; $display("FAIL vec%0d_latency got %0d want 5", i, lat); end
            checks++; if (bus.result !== v_r[i]) begin errors++; $display("FAIL vec%0d_result got %h want %h", i, bus.result, v_r[i]); end
            checks++; if (bus.carry_out !== v_c[i]) begin errors++; $display("FAIL vec%0d_carry got %b want %b", i, bus.carry_out, v_c[i]); end
            checks++; if (bus.overflow !== v_v[i]) begin errors++; $display("FAIL vec%0d_ovf got %b want %b", i, bus.overflow, v_v[i]); end
        end
    endtask

    task automatic test_start_ignored;
        start_op(1'b0, 16'h1111, 16'h2222);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_busy%0d got %b want 1", n, bus.busy); end
            bus.start = 1'b1;
            bus.a     = 16'hFFFF;
            bus.b     = 16'hFFFF;
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ign_done got %b want 1", bus.done); end
        checks++; if (bus.result !== 16'h3333) begin errors++; $display("FAIL ign_result got %h want 3333", bus.result); end
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        start_op(1'b0, 16'h0001, 16'h0002);
        wait_done(lat, bc);
        checks++; if (bus.result !== 16'h0003) begin errors++; $display("FAIL b2b_first got %h want 0003", bus.result); end
        // Still in the done cycle: request the next operation here
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 16'h0010;
        bus.b     = 16'h0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency got %0d want 5", lat); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 4", bc); end
        checks++; if (bus.result !== 16'h000F) begin errors++; $display("FAIL b2b_second got %h want 000f", bus.result); end
        checks++; if (bus.carry_out !== 1'b1) begin errors++; $display("FAIL b2b_carry got %b want 1", bus.carry_out); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_dup_done got %b want 0", bus.done); end
    endtask

    task automatic test_result_hold;
        start_op(1'b0, 16'h1000, 16'h2000);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            checks++; if (bus.result !== 16'h000F) begin errors++; $display("FAIL hold%0d got %h want 000f", n, bus.result); end
        end
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL hold_done got %b want 1", bus.done); end
        checks++; if (bus.result !== 16'h3000) begin errors++; $display("FAIL hold_new got %h want 3000", bus.result); end
    endtask

    task automatic test_reset_mid_run;
        int lat, bc;
        start_op(1'b0, 16'h7000, 16'h7000);
        wait_done(lat, bc);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL rst_pre_ovf got %b want 1", bus.overflow); end
        start_op(1'b0, 16'h1234, 16'h1111);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL rst_result got %h want 0000", bus.result); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", bus.overflow); end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_no_done%0d got %b want 0", n, bus.done); end
        end
        rst_n = 1'b1;
        start_op(1'b0, 16'h00FF, 16'h0001);
        wait_done(lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL rst_after_latency got %0d want 5", lat); end
        checks++; if (bus.result !== 16'h0100) begin errors++; $display("FAIL rst_after_result got %h want 0100", bus.result); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_add_timing;
        test_vectors;
        test_start_ignored;
        test_back_to_back;
        test_result_hold;
        test_reset_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
